// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: the fetch-queue entry layout and pipeline widths.
package cpu_pkg;

  localparam int FQ_XLEN  = 32;
  localparam int FETCH_W  = 1;
  localparam int DECODE_W = 2;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
    logic               pred_taken;
  } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Fetch-queue entry array: one synchronous write port, two asynchronous read ports.
module fq_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_en,
  input  logic [AW-1:0] write_addr,
  input  fq_entry_t     write_data,
  input  logic [AW-1:0] read_addr0,
  input  logic [AW-1:0] read_addr1,
  output fq_entry_t     read_data0,
  output fq_entry_t     read_data1
);

  fq_entry_t mem [DEPTH];

  // Entries are zeroed on reset so the stale-slot read data is never X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data0 = mem[read_addr0];
  assign read_data1 = mem[read_addr1];

endmodule

// File: rtl/fetch_queue.sv
// In-order decoupling queue between fetch (one entry/cycle) and two-wide decode.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [XLEN-1:0]                    in_pc,
  input  logic [XLEN-1:0]                    in_instr,
  input  logic                               in_pred_taken,
  output logic [DECODE_W-1:0]                out_valid,
  input  logic [DECODE_W-1:0]                out_ready,
  output logic [DECODE_W-1:0][XLEN-1:0]      out_pc,
  output logic [DECODE_W-1:0][XLEN-1:0]      out_instr,
  output logic [DECODE_W-1:0]                out_pred_taken,
  output logic [$clog2(DEPTH):0]             count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          enq;
  logic          deq0;
  logic          deq1;
  logic [1:0]    deq_n;
  fq_entry_t     write_data;
  fq_entry_t     slot0;
  fq_entry_t     slot1;

  assign in_ready     = (count != CW'(DEPTH));
  assign out_valid[0] = (count != '0);
  assign out_valid[1] = (count >= CW'(2));

  assign enq = in_valid && in_ready && !flush;

  // Slot 1 may only retire alongside slot 0, keeping consumption in order.
  assign deq0  = out_valid[0] && out_ready[0];
  assign deq1  = deq0 && out_valid[1] && out_ready[1];
  assign deq_n = deq1 ? 2'd2 : (deq0 ? 2'd1 : 2'd0);

  assign write_data.pc         = in_pc;
  assign write_data.instr      = in_instr;
  assign write_data.pred_taken = in_pred_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq_n);
      tail  <= tail + AW'(enq);
      count <= count + CW'(enq) - CW'(deq_n);
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk        (clk),
    .reset      (reset),
    .write_en   (enq),
    .write_addr (tail),
    .write_data (write_data),
    .read_addr0 (head),
    .read_addr1 (head + AW'(1)),
    .read_data0 (slot0),
    .read_data1 (slot1)
  );

  assign out_pc[0]         = slot0.pc;
  assign out_pc[1]         = slot1.pc;
  assign out_instr[0]      = slot0.instr;
  assign out_instr[1]      = slot1.instr;
  assign out_pred_taken[0] = slot0.pred_taken;
  assign out_pred_taken[1] = slot1.pred_taken;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the fetch stage and the two-wide decode/rename stage inside `CPU_top`. It accepts one fetched instruction per cycle, holds up to `DEPTH` entries in program order, and presents the two oldest entries to decode each cycle. It absorbs fetch/decode rate mismatch and is cleared in one cycle on a pipeline flush (branch mispredict or exception redirect).

## Interface
Parameters:
- `DEPTH`, 8: entry count; must be a power of two, ≥ 4.
- `XLEN`, 32: PC and instruction width.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting it clears the queue immediately.
- `flush`  in  1  synchronous clear; priority over enqueue and dequeue.
- `in_valid`  in  1  fetch presents an entry.
- `in_ready`  out  1  queue can accept an entry this cycle.
- `in_pc`  in  XLEN  PC of the fetched instruction.
- `in_instr`  in  XLEN  instruction word.
- `in_pred_taken`  in  1  branch predictor taken bit.
- `out_valid`  out  2  bit i: slot i holds a valid entry (slot 0 = oldest).
- `out_ready`  in  2  bit i: decode consumes slot i this cycle.
- `out_pc`  out  2×XLEN  PCs of slots 0 and 1.
- `out_instr`  out  2×XLEN  instruction words of slots 0 and 1.
- `out_pred_taken`  out  2  predictor bits of slots 0 and 1.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: circular buffer, head (oldest) and tail (next write) pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH; separate occupancy counter.
- Enqueue fires when `in_valid && in_ready && !flush`; writes the entry at tail; tail += 1.
- `in_ready = (count != DEPTH)`; it does not depend on same-cycle dequeue (no full-queue pass-through).
- `out_valid[0] = (count >= 1)`, `out_valid[1] = (count >= 2)`; slot 0 reads head, slot 1 reads head+1 (wrapped).
- Dequeue count: 0 if `!(out_valid[0] && out_ready[0])`; 1 if slot 0 fires and slot 1 does not; 2 if both fire. `out_ready[1]` without `out_ready[0]` is ignored (in-order consumption only). head += dequeue count.
- Next count = count + enq − deq; simultaneous enqueue and dequeue at any occupancy is legal.
- Flush: head, tail, count ← 0; same-cycle enqueue and dequeue are discarded.
- Out-of-range `out_*` data when the matching valid bit is low is don't-care, but must be free of X after the first write.

## Timing
- Reset (async, `reset` low): head = tail = count = 0; `in_ready` = 1, `out_valid` = 2'b00. Takes effect without a clock edge; deasserts synchronously on the next rising edge.
- Enqueue-to-visible latency: 1 cycle (entry written at edge N appears on slot 0 after edge N if queue was empty). No combinational path from `in_*` to `out_*`.
- `in_ready`, `out_valid`, `out_*` data and `count` are functions of registered state only; `out_ready` affects only the next state.
- Flush asserted at edge N: from N onward `out_valid` = 0 and `in_ready` = 1.
- Reset asserted mid-operation: all entries are lost; no partial dequeue is reported.

## Structure
- Shared package `cpu_pkg`: `fq_entry_t` packed struct {pc, instr, pred_taken}; `FETCH_W = 1`, `DECODE_W = 2` constants.
- One sub-module is natural: `fq_storage`, a DEPTH×`fq_entry_t` register array with one write port and two asynchronous read ports; pointer/count control stays in `fetch_queue`.

## Test plan
- Reset: hold `reset` low mid-clock, no edge → `count` = 0, `in_ready` = 1, `out_valid` = 00 immediately.
- Fill: 8 back-to-back enqueues (PC 0x100..0x11C), `out_ready` = 00 → `count` = 8, `in_ready` = 0; 9th `in_valid` is not accepted.
- Dual drain with wrap: from full, `out_ready` = 11 for 4 cycles while enqueuing PC 0x120..0x12C → slots present 0x100/0x104, 0x108/0x10C, …, then 0x120 onward in order; head and tail wrap past index 7 without loss.
- Single dequeue plus enqueue at count = 1: `out_ready` = 01, `in_valid` = 1 → `count` stays 1, slot 0 shows the new PC next cycle.
- Illegal ready pattern: `out_ready` = 10 with count = 3 → dequeue count 0; `count` stays 3.
- Flush with simultaneous enqueue/dequeue at count = 5 → next cycle `count` = 0, `out_valid` = 00; following enqueue of PC 0x200 appears alone on slot 0.
